paddle_ctrl: RTL and testbench
==============================

// Module: paddle_ctrl
//
// PURPOSE
//   Downstream consumer of the breadboard button stage. Takes the two active-low
//   move requests (up_n, down_n) and maintains one pong paddle's vertical
//   position, with a tick-paced speed and hold-to-accelerate.
//   paddle_y feeds the renderer and collision logic.
//
// PARAMETERS
//   SCREEN_H    480     visible lines; paddle_y max = SCREEN_H-PADDLE_H (MAX_Y)
//   PADDLE_H    80      paddle height in lines
//   STEP        4       lines moved per tick in SLOW; FAST moves 2*STEP
//   TICK_DIV    416667  clk cycles per move tick (100 MHz -> 240 Hz)
//   HOLD_TICKS  24      SLOW ticks before promotion to FAST
//
// PORTS
//   clk        in   1   system clock, all logic on posedge
//   rst_n      in   1   synchronous reset, active-low
//   up_n       in   1   move-up request, active-low, async to clk
//   down_n     in   1   move-down request, active-low, async to clk
//   paddle_y   out  10  top line of paddle, 0..MAX_Y; up decreases y
//   at_top     out  1   paddle_y == 0
//   at_bottom  out  1   paddle_y == MAX_Y
//   moving     out  1   state != IDLE
//
// BEHAVIOUR
//   Reset (rst_n low at posedge):
//   - paddle_y = (SCREEN_H-PADDLE_H)/2 (200 at defaults).
//   - State = IDLE; tick_cnt = 0; hold_cnt = 0.
//   - Synchroniser flops = 1 (released).
//   - Outputs: at_top = 0, at_bottom = 0, moving = 0.
//   - Reset mid-move takes effect on that edge; nothing else is retained.
//   Synchroniser:
//   - up_n and down_n each pass through 2 flops.
//   - req_up = ~up_s & down_s; req_dn = ~down_s & up_s.
//   - Both low or both high = no request.
//   Tick:
//   - tick_cnt counts 0..TICK_DIV-1 and wraps. It is free-running and never
//     cleared by requests.
//   - tick = (tick_cnt == TICK_DIV-1), one cycle wide.
//   FSM: IDLE, SLOW, FAST, plus a dir register (0 = up, 1 = down).
//   - IDLE: any request -> SLOW; dir = request; hold_cnt = 0. No move on that
//     edge.
//   - SLOW/FAST, no request -> IDLE on the next edge. No move, even if tick.
//   - SLOW/FAST, request opposite to dir -> SLOW; dir flips; hold_cnt = 0.
//     No move on that edge.
//   - SLOW, same dir, tick -> move STEP. If hold_cnt == HOLD_TICKS-1, go to
//     FAST; otherwise hold_cnt++.
//   - FAST, same dir, tick -> move 2*STEP.
//   Arithmetic (11-bit intermediates, saturating, never wraps):
//   - Up: y < s ? 0 : y - s.
//   - Down: y + s > MAX_Y ? MAX_Y : y + s.
//   Outputs:
//   - at_top, at_bottom, moving are decoded from registered state and paddle_y.
//   Latency:
//   - A pin change is seen by the FSM on the 3rd posedge.
//   - First move lands on the first tick after entering SLOW.
//
// TESTING (TICK_DIV=4, HOLD_TICKS=3, STEP=4, defaults otherwise; MAX_Y=400)
//   1. rst_n low 3 cycles, buttons released -> paddle_y=200, moving=0,
//      at_top=0, at_bottom=0.
//   2. up_n low for 5 ticks -> paddle_y 196, 192, 188 (SLOW), then 180, 172
//      (FAST); moving=1.
//   3. up_n held low until settled -> paddle_y reaches 0 exactly, at_top=1,
//      stays 0 on later ticks (no wrap to 1020).
//   4. up_n and down_n both low for 10 ticks -> paddle_y unchanged at 200,
//      moving=0.
//   5. FAST going up, then switch to down_n only -> SLOW, next tick +4, not +8;
//      down_n held -> saturates at 400, at_bottom=1.
//   6. Mid-FAST, rst_n low 1 cycle -> next edge paddle_y=200, moving=0; a 1-cycle
//      up_n glitch between ticks -> no move.

Source files
------------

// File: rtl/paddle_ctrl.sv
// paddle_ctrl: turns synchronised active-low up/down buttons into a paddle
// position that moves once per tick, speeding up after a sustained hold.
module paddle_ctrl #(
    parameter int unsigned SCREEN_H   = 480,
    parameter int unsigned PADDLE_H   = 80,
    parameter int unsigned STEP       = 4,
    parameter int unsigned TICK_DIV   = 416667,
    parameter int unsigned HOLD_TICKS = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       up_n,
    input  logic       down_n,
    output logic [9:0] paddle_y,
    output logic       at_top,
    output logic       at_bottom,
    output logic       moving
);

    localparam int unsigned Y_W     = 10;
    localparam int unsigned ARITH_W = 11;
    localparam int unsigned MAX_Y   = SCREEN_H - PADDLE_H;
    localparam int unsigned Y_INIT  = MAX_Y / 2;
    localparam int unsigned TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned HOLD_W  = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SLOW = 2'd1,
        FAST = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                dir;
    logic                dir_nxt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   hold_nxt;
    logic [TICK_W-1:0]   tick_cnt;
    logic                tick;
    logic                up_meta;
    logic                up_s;
    logic                down_meta;
    logic                down_s;
    logic                req_up;
    logic                req_dn;
    logic                move_en;
    logic                move_fast;
    logic [ARITH_W-1:0]  step_amt;
    logic [ARITH_W-1:0]  y_ext;
    logic [ARITH_W-1:0]  y_sum;
    logic [Y_W-1:0]      y_nxt;
    logic                at_top_nxt;
    logic                at_bottom_nxt;
    logic                moving_nxt;

    // Two-flop synchronisers; released (high) out of reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            up_meta   <= 1'b1;
            up_s      <= 1'b1;
            down_meta <= 1'b1;
            down_s    <= 1'b1;
        end else begin
            up_meta   <= up_n;
            up_s      <= up_meta;
            down_meta <= down_n;
            down_s    <= down_meta;
        end
    end

    // Only one button pressed counts as a request
    assign req_up = ~up_s & down_s;
    assign req_dn = ~down_s & up_s;

    // Free-running move-tick divider
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

    // FSM state register with direction and hold counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            dir      <= 1'b0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            dir      <= dir_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // Next-state: direction changes restart in SLOW, ticks advance the hold count
    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        hold_nxt  = hold_cnt;
        move_en   = 1'b0;
        move_fast = 1'b0;
        case (state)
            IDLE: begin
                if (req_up || req_dn) begin
                    state_nxt = SLOW;
                    dir_nxt   = req_dn;
                    hold_nxt  = '0;
                end
            end
            SLOW, FAST: begin
                if (!req_up && !req_dn) begin
                    state_nxt = IDLE;
                end else if (req_dn != dir) begin
                    state_nxt = SLOW;
                    dir_nxt   = req_dn;
                    hold_nxt  = '0;
                end else if (tick) begin
                    move_en   = 1'b1;
                    move_fast = (state == FAST);
                    if (state == SLOW) begin
                        if (hold_cnt == HOLD_W'(HOLD_TICKS - 1)) begin
                            state_nxt = FAST;
                        end else begin
                            hold_nxt = hold_cnt + HOLD_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output logic: saturating position update and status flags for next cycle
    always_comb begin
        step_amt      = move_fast ? ARITH_W'(2 * STEP) : ARITH_W'(STEP);
        y_ext         = ARITH_W'(paddle_y);
        y_sum         = y_ext + step_amt;
        y_nxt         = paddle_y;
        if (move_en) begin
            if (dir) begin
                y_nxt = (y_sum > ARITH_W'(MAX_Y)) ? Y_W'(MAX_Y) : Y_W'(y_sum);
            end else begin
                y_nxt = (y_ext < step_amt) ? '0 : Y_W'(y_ext - step_amt);
            end
        end
        at_top_nxt    = (y_nxt == '0);
        at_bottom_nxt = (y_nxt == Y_W'(MAX_Y));
        moving_nxt    = (state_nxt != IDLE);
    end

    // Registered position and status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            paddle_y  <= Y_W'(Y_INIT);
            at_top    <= 1'b0;
            at_bottom <= 1'b0;
            moving    <= 1'b0;
        end else begin
            paddle_y  <= y_nxt;
            at_top    <= at_top_nxt;
            at_bottom <= at_bottom_nxt;
            moving    <= moving_nxt;
        end
    end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: cycle model feeding a scoreboard, plus directed scenarios.
module tb_paddle_ctrl;

    localparam int TD    = 4;
    localparam int HT    = 3;
    localparam int ST    = 4;
    localparam int MAXY  = 400;
    localparam int YINIT = 200;

    typedef struct {
        int y;
        bit top;
        bit bot;
        bit mov;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       up_n;
    logic       down_n;
    logic [9:0] paddle_y;
    logic       at_top;
    logic       at_bottom;
    logic       moving;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    paddle_ctrl #(
        .SCREEN_H  (480),
        .PADDLE_H  (80),
        .STEP      (ST),
        .TICK_DIV  (TD),
        .HOLD_TICKS(HT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_n     (up_n),
        .down_n   (down_n),
        .paddle_y (paddle_y),
        .at_top   (at_top),
        .at_bottom(at_bottom),
        .moving   (moving)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Behavioural cycle model; one expected output set per posedge
    bit m_u1, m_u2, m_d1, m_d2, m_dir;
    int m_y, m_state, m_hold, m_tick;

    always @(posedge clk) begin
        bit   rq_up, rq_dn, tk;
        int   s;
        exp_t e;
        if (!rst_n) begin
            m_u1 = 1; m_u2 = 1; m_d1 = 1; m_d2 = 1;
            m_y = YINIT; m_state = 0; m_dir = 0; m_hold = 0; m_tick = 0;
        end else begin
            rq_up = !m_u2 && m_d2;
            rq_dn = !m_d2 && m_u2;
            tk    = (m_tick == TD - 1);
            if (m_state == 0) begin
                if (rq_up || rq_dn) begin
                    m_state = 1; m_dir = rq_dn; m_hold = 0;
                end
            end else if (!rq_up && !rq_dn) begin
                m_state = 0;
            end else if (rq_dn != m_dir) begin
                m_state = 1; m_dir = rq_dn; m_hold = 0;
            end else if (tk) begin
                s = (m_state == 2) ? 2 * ST : ST;
                if (m_dir) m_y = (m_y + s > MAXY) ? MAXY : m_y + s;
                else       m_y = (m_y < s) ? 0 : m_y - s;
                if (m_state == 1) begin
                    if (m_hold == HT - 1) m_state = 2;
                    else                  m_hold++;
                end
            end
            m_u2 = m_u1; m_u1 = up_n;
            m_d2 = m_d1; m_d1 = down_n;
            m_tick = tk ? 0 : m_tick + 1;
        end
        e.y = m_y; e.top = (m_y == 0); e.bot = (m_y == MAXY); e.mov = (m_state != 0);
        exp_q.push_back(e);
    end

    // Scoreboard: compare each modelled edge at the following negedge
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("sb_y",      32'(paddle_y),  32'(e.y));
            check_eq("sb_top",    32'(at_top),    32'(e.top));
            check_eq("sb_bottom", 32'(at_bottom), 32'(e.bot));
            check_eq("sb_moving", 32'(moving),    32'(e.mov));
        end
    end

    task automatic wait_y_change(input string tag, input int bound, output logic [9:0] v);
        logic [9:0] prev;
        bit         seen;
        prev = paddle_y;
        seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (paddle_y !== prev) seen = 1;
        end
        check_eq(tag, 32'(seen), 32'd1);
        v = paddle_y;
    endtask

    task automatic wait_y_equal(input string tag, input int bound, input int target);
        bit seen;
        seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (paddle_y == 10'(target)) seen = 1;
        end
        check_eq(tag, 32'(seen), 32'd1);
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [9:0] v;
        int t2[5] = '{196, 192, 188, 180, 172};
        rst_n = 1'b0; up_n = 1'b1; down_n = 1'b1;

        // 1: reset state
        repeat (3) @(negedge clk);
        check_eq("rst_y",      32'(paddle_y),  32'(YINIT));
        check_eq("rst_moving", 32'(moving),    32'd0);
        check_eq("rst_top",    32'(at_top),    32'd0);
        check_eq("rst_bottom", 32'(at_bottom), 32'd0);
        rst_n = 1'b1;

        // 2: hold up through SLOW into FAST
        up_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_y_change("t2_wait", 40, v);
            check_eq("t2_y", 32'(v), 32'(t2[i]));
        end
        check_eq("t2_moving", 32'(moving), 32'd1);

        // 3: saturate at the top
        wait_y_equal("t3_reach0", 400, 0);
        check_eq("t3_top", 32'(at_top), 32'd1);
        repeat (12) @(negedge clk);
        check_eq("t3_hold0", 32'(paddle_y), 32'd0);
        check_eq("t3_top_hold", 32'(at_top), 32'd1);
        up_n = 1'b1;
        do_reset(1);

        // 4: both buttons pressed is no request
        up_n = 1'b0; down_n = 1'b0;
        repeat (10 * TD) @(negedge clk);
        check_eq("t4_y",      32'(paddle_y), 32'(YINIT));
        check_eq("t4_moving", 32'(moving),   32'd0);
        up_n = 1'b1; down_n = 1'b1;
        repeat (4) @(negedge clk);

        // 5: reverse out of FAST restarts SLOW, then saturate at bottom
        up_n = 1'b0;
        for (int i = 0; i < 4; i++) wait_y_change("t5_up_wait", 40, v);
        check_eq("t5_fast_y", 32'(v), 32'd180);
        up_n = 1'b1; down_n = 1'b0;
        wait_y_change("t5_dn_wait", 40, v);
        check_eq("t5_slow_step", 32'(v), 32'd184);
        wait_y_equal("t5_reach400", 1000, MAXY);
        check_eq("t5_bottom", 32'(at_bottom), 32'd1);
        repeat (12) @(negedge clk);
        check_eq("t5_hold400", 32'(paddle_y), 32'(MAXY));
        down_n = 1'b1;
        repeat (8) @(negedge clk);

        // 6: reset in FAST, then a one-cycle glitch
        up_n = 1'b0;
        for (int i = 0; i < 4; i++) wait_y_change("t6_up_wait", 40, v);
        rst_n = 1'b0; up_n = 1'b1;
        @(negedge clk);
        check_eq("t6_rst_y",      32'(paddle_y), 32'(YINIT));
        check_eq("t6_rst_moving", 32'(moving),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        up_n = 1'b0;
        @(negedge clk);
        up_n = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("t6_glitch_y",      32'(paddle_y), 32'(YINIT));
        check_eq("t6_glitch_moving", 32'(moving),   32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
